// File: rtl/line_timing_gen_pkg.sv
// Shared types and default timing constants for the horizontal line timing
// generator and its horizontal segment counter.
package line_timing_pkg;

    // Line-level state of the timing generator.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK,
        ST_VBLANK
    } state_e;

    localparam int DEF_H_ACTIVE = 32;
    localparam int DEF_H_FRONT  = 4;
    localparam int DEF_H_SYNC   = 8;
    localparam int DEF_H_BACK   = 4;
    localparam int DEF_V_GAP    = 16;
    localparam int DEF_CNT_W    = 8;

    // Frame-length check: number of lines without endFrame that flags an error.
    localparam int LINE_CNT_W       = 6;
    localparam int FRAME_LINE_LIMIT = 33;

    // Total cycles of one line across all four horizontal segments.
    function automatic int h_total(input int h_active, input int h_front,
                                   input int h_sync, input int h_back);
        return h_active + h_front + h_sync + h_back;
    endfunction

endpackage

// File: rtl/line_timing_gen_if.sv
// Bus between the line timing generator (master) and the line/frame counter
// plus pixel pipeline that consume its timing (slave).
interface line_timing_gen_if import line_timing_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
);
    logic             enb;
    logic             endFrame;
    logic             newLine;
    logic             b5_enb;
    logic             hactive;
    logic             hsync;
    logic [CNT_W-1:0] pix_x;
    logic             frameStart;
    logic             frame_err;

    modport master (
        input  enb, endFrame,
        output newLine, b5_enb, hactive, hsync, pix_x, frameStart, frame_err
    );

    modport slave (
        output enb, endFrame,
        input  newLine, b5_enb, hactive, hsync, pix_x, frameStart, frame_err
    );
endinterface

// File: rtl/line_timing_gen_h_seg_counter.sv
// Horizontal position counter for one line. Counts while a line is running,
// wraps to 0 after the last line cycle and sits at 0 otherwise. Decodes the
// last cycle of each horizontal segment from the current count.
module h_seg_counter import line_timing_pkg::*; #(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [CNT_W-1:0] cnt_next,
    output logic             is_last_active,
    output logic             is_last_front,
    output logic             is_last_sync,
    output logic             is_line_end
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);

    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(H_ACTIVE + H_FRONT - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] LINE_END    = CNT_W'(H_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] h_cnt_d;

    // Segment boundary decode on the current count.
    always_comb begin
        is_last_active = (h_cnt_q == LAST_ACTIVE);
        is_last_front  = (h_cnt_q == LAST_FRONT);
        is_last_sync   = (h_cnt_q == LAST_SYNC);
        is_line_end    = (h_cnt_q == LINE_END);
    end

    // Advance within a running line, wrap at line end, park at 0 when idle.
    always_comb begin
        h_cnt_d = '0;
        if (run && !is_line_end) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
        end
    end

    assign cnt_next = h_cnt_d;

endmodule

// File: rtl/line_timing_gen.sv
// Horizontal timing generator: active/front/sync/back segments per line,
// newLine pulse on the last line cycle, vertical blanking after endFrame.
// All outputs are registered from the next state, so they line up with the
// state register. Optional frame-length check enabled by FRAME_LEN_CHK_EN.
module line_timing_gen import line_timing_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_GAP    = DEF_V_GAP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    line_timing_gen_if.master bus
);
    localparam int               H_TOTAL  = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam logic [CNT_W-1:0] LINE_END = CNT_W'(H_TOTAL - 1);
    localparam int               V_W      = $clog2(V_GAP + 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_GAP - 1);

    state_e           state_q, state_d;
    logic [V_W-1:0]   v_cnt_q, v_cnt_d;
    logic             end_pend_q, end_pend_d;
    logic             line_run;
    logic [CNT_W-1:0] h_cnt_next;
    logic             is_last_active, is_last_front, is_last_sync, is_line_end;

    logic             new_line_q, new_line_d;
    logic             b5_enb_q, b5_enb_d;
    logic             hactive_q, hactive_d;
    logic             hsync_q, hsync_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_err_q;

    assign line_run = (state_q == ST_ACTIVE) || (state_q == ST_FRONT) ||
                      (state_q == ST_SYNC)   || (state_q == ST_BACK);

    h_seg_counter #(
        .CNT_W    (CNT_W),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK)
    ) u_h_seg_counter (
        .clk            (clk),
        .rst            (rst),
        .run            (line_run),
        .cnt_next       (h_cnt_next),
        .is_last_active (is_last_active),
        .is_last_front  (is_last_front),
        .is_last_sync   (is_last_sync),
        .is_line_end    (is_line_end)
    );

    // State, blanking counter and pending end-of-frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            v_cnt_q    <= '0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_cnt_q    <= v_cnt_d;
            end_pend_q <= end_pend_d;
        end
    end

    // Next state: walk the segments; at line end an end-of-frame beats enb.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.enb) state_d = ST_ACTIVE;
            ST_ACTIVE: if (is_last_active) state_d = ST_FRONT;
            ST_FRONT:  if (is_last_front) state_d = ST_SYNC;
            ST_SYNC:   if (is_last_sync) state_d = ST_BACK;
            ST_BACK: begin
                if (is_line_end) begin
                    if (end_pend_q || bus.endFrame) state_d = ST_VBLANK;
                    else if (!bus.enb)              state_d = ST_IDLE;
                    else                            state_d = ST_ACTIVE;
                end
            end
            ST_VBLANK: begin
                if (v_cnt_q == V_LAST) state_d = bus.enb ? ST_ACTIVE : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Blanking length count and endFrame capture for the current line.
    always_comb begin
        v_cnt_d    = (state_q == ST_VBLANK) ? v_cnt_q + 1'b1 : '0;
        end_pend_d = 1'b0;
        if (line_run && !is_line_end) begin
            end_pend_d = end_pend_q | bus.endFrame;
        end
    end

    // Output decode from the next state and next horizontal position.
    always_comb begin
        hactive_d     = (state_d == ST_ACTIVE);
        pix_x_d       = hactive_d ? h_cnt_next : '0;
        hsync_d       = (state_d == ST_SYNC);
        new_line_d    = (state_d == ST_BACK) && (h_cnt_next == LINE_END);
        b5_enb_d      = (state_d == ST_ACTIVE) || (state_d == ST_FRONT) ||
                        (state_d == ST_SYNC)   || (state_d == ST_BACK);
        frame_start_d = (state_d == ST_ACTIVE) &&
                        ((state_q == ST_IDLE) || (state_q == ST_VBLANK));
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_line_q    <= 1'b0;
            b5_enb_q      <= 1'b0;
            hactive_q     <= 1'b0;
            hsync_q       <= 1'b0;
            pix_x_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            new_line_q    <= new_line_d;
            b5_enb_q      <= b5_enb_d;
            hactive_q     <= hactive_d;
            hsync_q       <= hsync_d;
            pix_x_q       <= pix_x_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef FRAME_LEN_CHK_EN
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  frame_err_d;

    // Lines seen in this frame (saturating); a line past the limit that does
    // not close the frame latches the error.
    always_comb begin
        line_cnt_d  = line_cnt_q;
        frame_err_d = frame_err_q;
        if (frame_start_q) begin
            line_cnt_d = '0;
        end else if (new_line_q && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
        if (new_line_q && (line_cnt_q >= LINE_CNT_W'(FRAME_LINE_LIMIT - 1)) &&
            !(end_pend_q || bus.endFrame)) begin
            frame_err_d = 1'b1;
        end
    end

    // Line count and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            line_cnt_q  <= line_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end
`else
    assign frame_err_q = 1'b0;
`endif

    assign bus.newLine    = new_line_q;
    assign bus.b5_enb     = b5_enb_q;
    assign bus.hactive    = hactive_q;
    assign bus.hsync      = hsync_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.frameStart = frame_start_q;
    assign bus.frame_err  = frame_err_q;

endmodule
